vga_sync_recovery: RTL and testbench
====================================

VGA_SYNC_RECOVERY -- requirements
Module: vga_sync_recovery

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive matching frames needed before locked asserts (range 1..15).
REQ-002 SHALL have parameter CNT_MAX, default 2047, meaning the saturation value of every internal counter and the line timeout.
REQ-003 SHALL have port pclk  input  1  pixel clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  active-high sync/blank from a timing generator, synchronous to pclk.
REQ-006 SHALL have ports hcount_rec, vcount_rec  output  11 each  recovered pixel/line position.
REQ-007 SHALL have ports h_total, v_total  output  11 each  last measured line length (pclk cycles) and frame length (lines).
REQ-008 SHALL have ports locked  output  1  and timing_err  output  1  (single-cycle error pulse).
REQ-009 SHALL have ports hs_start, hs_width  output  11 each  measured hsync position and width (see Configuration).

Function
REQ-010 SHALL register every input once (x_s1); all detection uses x_s1 and the raw input, and all outputs are registered.
REQ-011 Line-start event L SHALL be the cycle where hblnk_in==0 and hblnk_s1==1; hcount_rec SHALL load 0 on that edge, so hcount_rec==0 during the first cycle with hblnk_s1==0 (1-cycle latency vs. input).
REQ-012 Between L events, hcount_rec SHALL increment by 1 per cycle and saturate at CNT_MAX.
REQ-013 On L, h_total SHALL load hcount_rec+1 (saturating at CNT_MAX).
REQ-014 On every L, vblnk_in SHALL be latched into vb_line; frame-start event F SHALL be an L with vblnk_in==0 and vb_line==1.
REQ-015 On F, vcount_rec SHALL load 0 and v_total SHALL load vcount_rec+1; on an L that is not F, vcount_rec SHALL increment, saturating at CNT_MAX.
REQ-016 State machine SHALL have states SEARCH, ACQUIRE, LOCKED; locked==1 only in LOCKED.
REQ-017 SEARCH -> ACQUIRE on F when the previous two L events gave equal h_total; match counter cleared.
REQ-018 ACQUIRE: each F with new v_total equal to previous v_total and every line of that frame equal to h_total SHALL increment the match counter; any mismatch SHALL clear it and stay in ACQUIRE; counter reaching LOCK_FRAMES -> LOCKED.
REQ-019 LOCKED: any L with hcount_rec+1 != h_total, or any F with vcount_rec+1 != v_total, SHALL pulse timing_err for one cycle and go to SEARCH; h_total/v_total still update with the new measurement.
REQ-020 Timeout: hcount_rec reaching CNT_MAX in any state SHALL force SEARCH, and SHALL pulse timing_err once if the state was LOCKED.
REQ-021 Simultaneous L and F SHALL be processed in the same cycle (F implies L); a mismatch at L and at F in the same cycle SHALL produce one timing_err pulse.

Reset
REQ-022 On rst: hcount_rec, vcount_rec, h_total, v_total, hs_start, hs_width = 0; locked=0; timing_err=0; state=SEARCH; match counter=0; vb_line=0; all x_s1=0.
REQ-023 rst asserted mid-frame SHALL take effect on the next edge; reacquisition SHALL restart from SEARCH with no stale measurement used.

Configuration
REQ-024 Macro VGA_SYNC_REC_SYNC_MEAS_EN defined: on hsync_in==1 && hsync_s1==0, hs_start SHALL load hcount_rec+1; hs_width SHALL count hsync_s1-high cycles and load the count on the hsync_s1 falling edge.
REQ-025 Macro undefined: the measurement logic SHALL be absent, and hs_start and hs_width SHALL be constant 0.

Verification
REQ-026 Drive 800x600 timing (line 1056, blank from 800, hsync 840..967; frame 628, vblank from line 600) -> after LOCK_FRAMES+2 frames, locked=1, h_total=1056, v_total=628, timing_err never asserted.
REQ-027 Locked, shorten one line to 1055 cycles -> timing_err pulses 1 cycle at that L, locked=0, h_total=1055, relock after subsequent clean frames.
REQ-028 Hold hblnk_in high 3000 cycles while locked -> hcount_rec saturates at 2047, one timing_err pulse, state SEARCH.
REQ-029 Assert rst for 1 cycle at line 300 -> all outputs 0 next cycle; locked reasserts only after full reacquisition.
REQ-030 With VGA_SYNC_REC_SYNC_MEAS_EN on 800x600 timing -> hs_start=840, hs_width=128; without the macro -> both 0.

Source files
------------

// File: rtl/vga_sync_recovery_if.sv
// Purpose: bundles the timing-generator inputs and the recovered-timing outputs of vga_sync_recovery.
// Latency: none, this is wiring only.
// Backpressure: none; the sync/blank stream is free-running and cannot be stalled.
// Ports (master = timing generator / observer side, slave = vga_sync_recovery):
//   hsync_in, vsync_in, hblnk_in, vblnk_in           sync/blank stream, active-high
//   hcount_rec, vcount_rec                            recovered pixel/line position
//   h_total, v_total                                  last measured line/frame length
//   locked, timing_err                                lock status, single-cycle error pulse
//   hs_start, hs_width                                measured hsync position/width
interface vga_sync_recovery_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [10:0] hcount_rec;
    logic [10:0] vcount_rec;
    logic [10:0] h_total;
    logic [10:0] v_total;
    logic        locked;
    logic        timing_err;
    logic [10:0] hs_start;
    logic [10:0] hs_width;

    modport master (
        output hsync_in, vsync_in, hblnk_in, vblnk_in,
        input  hcount_rec, vcount_rec, h_total, v_total,
        input  locked, timing_err, hs_start, hs_width
    );

    modport slave (
        input  hsync_in, vsync_in, hblnk_in, vblnk_in,
        output hcount_rec, vcount_rec, h_total, v_total,
        output locked, timing_err, hs_start, hs_width
    );
endinterface

// File: rtl/vga_sync_recovery.sv
// Purpose: recovers pixel/line position from a sync/blank stream, measures line/frame length and tracks lock.
// Latency: one pclk from input edge to counter/measurement update; every output is registered.
// Backpressure: none; one input sample is consumed every pclk.
// Ports: pclk, rst (synchronous, active-high); bus (vga_sync_recovery_if.slave) carries all stream I/O.
// Optional feature: define VGA_SYNC_REC_SYNC_MEAS_EN to measure hsync start/width; otherwise
// hs_start and hs_width are tied to 0.
module vga_sync_recovery #(
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_MAX     = 2047
) (
    input  logic               pclk,
    input  logic               rst,
    vga_sync_recovery_if.slave bus
);
    localparam logic [10:0] CMAX   = 11'(CNT_MAX);
    localparam logic [4:0]  LOCK_N = 5'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] x);
        return (x >= CMAX) ? CMAX : x + 11'd1;
    endfunction

    logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
    logic [10:0] hcount, vcount, htot, vtot;
    logic        vb_line;
    logic        line_ok;
    logic [3:0]  match_cnt;
    logic        locked_r, err_r;
    state_t      state;

    logic        line_ev, frame_ev, timeout, h_match, v_match;
    logic [10:0] h_meas, v_meas;

    // h_meas/v_meas are the length of the line/frame ending at this event, and also
    // the saturating increment used by the counters between events.
    assign line_ev  = !bus.hblnk_in && hblnk_s1;
    assign frame_ev = line_ev && !bus.vblnk_in && vb_line;
    assign h_meas   = sat_inc(hcount);
    assign v_meas   = sat_inc(vcount);
    assign h_match  = (h_meas == htot);
    assign v_match  = (v_meas == vtot);
    assign timeout  = (hcount == CMAX);

    always_ff @(posedge pclk) begin
        if (rst) begin
            hsync_s1 <= 1'b0;
            vsync_s1 <= 1'b0;
            hblnk_s1 <= 1'b0;
            vblnk_s1 <= 1'b0;
            hcount   <= '0;
            vcount   <= '0;
            htot     <= '0;
            vtot     <= '0;
            vb_line  <= 1'b0;
        end else begin
            hsync_s1 <= bus.hsync_in;
            vsync_s1 <= bus.vsync_in;
            hblnk_s1 <= bus.hblnk_in;
            vblnk_s1 <= bus.vblnk_in;
            if (line_ev) begin
                hcount  <= '0;
                htot    <= h_meas;
                vb_line <= bus.vblnk_in;
                if (frame_ev) begin
                    vcount <= '0;
                    vtot   <= v_meas;
                end else begin
                    vcount <= v_meas;
                end
            end else begin
                hcount <= h_meas;
            end
        end
    end

    // Lock tracker. Comparisons use the measurement of the event being processed
    // against the previous one still held in htot/vtot.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= SEARCH;
            match_cnt <= '0;
            line_ok   <= 1'b0;
            locked_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (timeout) begin
                // A line that never ends invalidates everything; report only a lost lock.
                if (state == LOCKED) err_r <= 1'b1;
                state     <= SEARCH;
                match_cnt <= '0;
                locked_r  <= 1'b0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (frame_ev && h_match) begin
                            state     <= ACQUIRE;
                            match_cnt <= '0;
                            line_ok   <= 1'b1;
                        end
                    end
                    ACQUIRE: begin
                        if (frame_ev) begin
                            line_ok <= 1'b1;
                            if (line_ok && h_match && v_match) begin
                                if ({1'b0, match_cnt} + 5'd1 == LOCK_N) begin
                                    state     <= LOCKED;
                                    locked_r  <= 1'b1;
                                    match_cnt <= '0;
                                end else begin
                                    match_cnt <= match_cnt + 4'd1;
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end else if (line_ev && !h_match) begin
                            line_ok <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        // Line and frame mismatches on the same event collapse into one pulse.
                        if ((line_ev && !h_match) || (frame_ev && !v_match)) begin
                            err_r     <= 1'b1;
                            state     <= SEARCH;
                            locked_r  <= 1'b0;
                            match_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.hcount_rec = hcount;
    assign bus.vcount_rec = vcount;
    assign bus.h_total    = htot;
    assign bus.v_total    = vtot;
    assign bus.locked     = locked_r;
    assign bus.timing_err = err_r;

`ifdef VGA_SYNC_REC_SYNC_MEAS_EN
    logic [10:0] hs_cnt, hs_start_r, hs_width_r;

    always_ff @(posedge pclk) begin
        if (rst) begin
            hs_cnt     <= '0;
            hs_start_r <= '0;
            hs_width_r <= '0;
        end else begin
            if (bus.hsync_in && !hsync_s1) hs_start_r <= h_meas;
            if (hsync_s1) hs_cnt <= sat_inc(hs_cnt);
            else          hs_cnt <= '0;
            // Last high cycle of hsync_s1: include it in the reported width.
            if (hsync_s1 && !bus.hsync_in) hs_width_r <= sat_inc(hs_cnt);
        end
    end

    assign bus.hs_start = hs_start_r;
    assign bus.hs_width = hs_width_r;

    logic unused_sig;
    assign unused_sig = ^{vsync_s1, vblnk_s1};
`else
    assign bus.hs_start = '0;
    assign bus.hs_width = '0;

    logic unused_sig;
    assign unused_sig = ^{vsync_s1, vblnk_s1, hsync_s1};
`endif
endmodule

// File: tb/tb_vga_sync_recovery.sv
// Purpose: self-checking bench for vga_sync_recovery driven by a programmable sync/blank generator.
// Latency: outputs compared one pclk after the stimulus edge, sampled on the falling edge.
// Backpressure: none; the generator runs freely.
module tb_vga_sync_recovery;
    localparam int LOCK_FRAMES = 2;
    localparam int CMAX        = 2047;
`ifdef VGA_SYNC_REC_SYNC_MEAS_EN
    localparam bit MEAS_EN = 1'b1;
`else
    localparam bit MEAS_EN = 1'b0;
`endif
    localparam int ST_SEARCH = 0;
    localparam int ST_ACQ    = 1;
    localparam int ST_LOCKED = 2;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    vga_sync_recovery_if bus ();

    vga_sync_recovery #(.LOCK_FRAMES(LOCK_FRAMES), .CNT_MAX(CMAX)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int err_pulses = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Positions are derived from edge timestamps: hcount is the number of edges since the
    // last line start (or reset), line length is the distance between line starts, and the
    // frame length is the number of line starts since the last frame start.
    int m_n, m_tlast, m_lines, m_bad_lines;
    int m_hcount, m_vcount, m_htot, m_vtot, m_hs_start, m_hs_width, m_hs_run;
    int m_st, m_good;
    bit m_phb, m_phs, m_vbline, m_err;

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    always @(posedge pclk) begin
        bit hb, vb, hs, ev_l, ev_f, hm, vm, to, frame_good;
        int len, vlen, hc_before;
        hb = bus.hblnk_in;
        vb = bus.vblnk_in;
        hs = bus.hsync_in;
        if (rst) begin
            m_n = 0; m_tlast = 0; m_lines = 0; m_bad_lines = 0;
            m_hcount = 0; m_vcount = 0; m_htot = 0; m_vtot = 0;
            m_hs_start = 0; m_hs_width = 0; m_hs_run = 0;
            m_st = ST_SEARCH; m_good = 0;
            m_phb = 0; m_phs = 0; m_vbline = 0; m_err = 0;
        end else begin
            m_n++;
            m_err = 0;
            hc_before = sat(m_n - 1 - m_tlast);
            to   = (hc_before == CMAX);
            ev_l = m_phb && !hb;
            ev_f = ev_l && !vb && m_vbline;
            hm = 0; vm = 0; frame_good = 0;
            if (ev_l) begin
                len      = sat(m_n - m_tlast);
                m_tlast  = m_n;
                hm       = (len == m_htot);
                m_htot   = len;
                m_vbline = vb;
                m_lines++;
                if (ev_f) begin
                    vlen       = sat(m_lines);
                    vm         = (vlen == m_vtot);
                    m_vtot     = vlen;
                    m_lines    = 0;
                    frame_good = (m_bad_lines == 0) && hm && vm;
                    m_bad_lines = 0;
                end else if (!hm) begin
                    m_bad_lines++;
                end
            end
            if (to) begin
                if (m_st == ST_LOCKED) m_err = 1;
                m_st = ST_SEARCH; m_good = 0;
            end else if (ev_l) begin
                if (m_st == ST_SEARCH) begin
                    if (ev_f && hm) begin m_st = ST_ACQ; m_good = 0; end
                end else if (m_st == ST_ACQ) begin
                    if (ev_f) begin
                        m_good = frame_good ? m_good + 1 : 0;
                        if (m_good >= LOCK_FRAMES) begin m_st = ST_LOCKED; m_good = 0; end
                    end
                end else begin
                    if (!hm || (ev_f && !vm)) begin m_err = 1; m_st = ST_SEARCH; m_good = 0; end
                end
            end
            m_hcount = sat(m_n - m_tlast);
            m_vcount = sat(m_lines);
            if (MEAS_EN) begin
                if (hs && !m_phs) m_hs_start = sat(hc_before + 1);
                if (!hs && m_phs) m_hs_width = sat(m_hs_run);
                m_hs_run = hs ? m_hs_run + 1 : 0;
            end
            m_phb = hb;
            m_phs = hs;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge pclk) begin
        logic [67:0] act, exp;
        if (chk_en) begin
            act = {bus.hcount_rec, bus.vcount_rec, bus.h_total, bus.v_total,
                   bus.hs_start, bus.hs_width, bus.locked, bus.timing_err};
            exp = {11'(m_hcount), 11'(m_vcount), 11'(m_htot), 11'(m_vtot),
                   11'(m_hs_start), 11'(m_hs_width), m_st == ST_LOCKED, m_err};
            n_chk++;
            if (act === exp) n_pass++;
            else $display("FAIL model_cycle t=%0t got hc=%0d vc=%0d ht=%0d vt=%0d hs=%0d hw=%0d lk=%0b err=%0b, expected %h",
                          $time, bus.hcount_rec, bus.vcount_rec, bus.h_total, bus.v_total,
                          bus.hs_start, bus.hs_width, bus.locked, bus.timing_err, exp);
            if (bus.timing_err) err_pulses++;
        end
    end

    // ---------------- generator ----------------
    int t_len, t_hb, t_hs0, t_hs1, t_lines, t_vb;

    task automatic set_timing(input int len, input int hb, input int hs0, input int hs1,
                              input int lines, input int vb);
        t_len = len; t_hb = hb; t_hs0 = hs0; t_hs1 = hs1; t_lines = lines; t_vb = vb;
    endtask

    task automatic drive(input bit hb, input bit vb, input bit hs, input bit vs);
        bus.hblnk_in = hb;
        bus.vblnk_in = vb;
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        @(posedge pclk);
        #1;
    endtask

    // Emits pixels h0..len-1 of the given line.
    task automatic gen_line(input int line, input int h0, input int len);
        for (int h = h0; h < len; h++)
            drive(h >= t_hb, line >= t_vb, (h >= t_hs0) && (h <= t_hs1), line == t_vb + 1);
    endtask

    task automatic gen_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int l = 0; l < t_lines; l++)
                gen_line(l, 0, t_len);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hcount"}, bus.hcount_rec, 0);
        check({tag, "_vcount"}, bus.vcount_rec, 0);
        check({tag, "_h_total"}, bus.h_total, 0);
        check({tag, "_v_total"}, bus.v_total, 0);
        check({tag, "_hs_start"}, bus.hs_start, 0);
        check({tag, "_hs_width"}, bus.hs_width, 0);
        check({tag, "_locked"}, bus.locked, 0);
        check({tag, "_timing_err"}, bus.timing_err, 0);
    endtask

    initial begin
        int p0;
        bus.hblnk_in = 1'b0;
        bus.vblnk_in = 1'b0;
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        rst = 1'b1;
        @(posedge pclk);
        #1;
        chk_en = 1'b1;
        @(posedge pclk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // 800x600 horizontal timing, short frame: 6 lines, vblank from line 4.
        set_timing(1056, 800, 840, 967, 6, 4);
        gen_frames(LOCK_FRAMES + 2);
        check("a_locked", bus.locked, 1);
        check("a_h_total", bus.h_total, 1056);
        check("a_v_total", bus.v_total, 6);
        check("a_hs_start", bus.hs_start, MEAS_EN ? 840 : 0);
        check("a_hs_width", bus.hs_width, MEAS_EN ? 128 : 0);
        check("a_no_err", err_pulses, 0);

        // One line shortened to 1055 while locked.
        gen_line(0, 0, 1056);
        gen_line(1, 0, 1056);
        gen_line(2, 0, 1055);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("b_err_pulse", bus.timing_err, 1);
        check("b_unlocked", bus.locked, 0);
        check("b_h_total", bus.h_total, 1055);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("b_err_single", bus.timing_err, 0);
        gen_line(3, 2, 1056);
        gen_line(4, 0, 1056);
        gen_line(5, 0, 1056);
        gen_frames(4);
        check("b_relocked", bus.locked, 1);
        check("b_h_total_back", bus.h_total, 1056);

        // Small timing: 100-cycle lines, 10-line frames.
        set_timing(100, 80, 84, 91, 10, 8);
        gen_frames(4);
        check("c_locked", bus.locked, 1);
        check("c_h_total", bus.h_total, 100);
        check("c_v_total", bus.v_total, 10);
        p0 = err_pulses;
        repeat (3000) drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("c_hcount_sat", bus.hcount_rec, 2047);
        check("c_one_err", err_pulses - p0, 1);
        check("c_search", bus.locked, 0);
        gen_frames(4);
        check("c_relocked", bus.locked, 1);

        // Reset mid-frame at line 3, pixel 50.
        gen_line(0, 0, 100);
        gen_line(1, 0, 100);
        gen_line(2, 0, 100);
        gen_line(3, 0, 50);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_all_zero("d_reset");
        gen_line(3, 51, 100);
        for (int l = 4; l < 10; l++) gen_line(l, 0, 100);
        gen_frames(3);
        check("d_not_yet_locked", bus.locked, 0);
        gen_frames(1);
        check("d_relocked", bus.locked, 1);

        @(negedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
